// File: rtl/obuf_pkg.sv
// Shared types and constants for the output-buffer drain block.
package obuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned FIFO_DEPTH = 4;

    // Index width for n items; a single item needs no index bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

endpackage

// File: rtl/obuf_lane_ram.sv
// One lane of the output buffer: a single write port and two independent
// registered read ports. A read colliding with a write returns the old data.
module obuf_lane_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic                  re_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a_q;
    logic [DATA_WIDTH-1:0] rd_b_q;

    // Storage array; deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read registers hold their value when their port is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (re_a_i) begin
                rd_a_q <= mem_q[raddr_a_i];
            end
            if (re_b_i) begin
                rd_b_q <= mem_q[raddr_b_i];
            end
        end
    end

    assign rdata_a_o = rd_a_q;
    assign rdata_b_o = rd_b_q;

endmodule

// File: rtl/obuf_drain.sv
// Output buffer with array-side read/write access and a streaming drain
// path that emits MEM_DATA_WIDTH words (one lane group each) through a
// small credit-controlled FIFO.
module obuf_drain
    import obuf_pkg::*;
#(
    parameter int unsigned ARRAY_M        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DATA_WIDTH = 64,
    parameter int unsigned BUF_ADDR_WIDTH = 10,
    localparam int unsigned GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH,
    localparam int unsigned NUM_GROUPS     = ARRAY_M / GROUP_SIZE,
    localparam int unsigned GRP_W          = idx_width(NUM_GROUPS),
    localparam int unsigned MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + GRP_W,
    localparam int unsigned BUF_DATA_WIDTH = ARRAY_M * DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      buf_write_req,
    input  logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
    input  logic [BUF_DATA_WIDTH-1:0] buf_write_data,
    input  logic                      buf_read_req,
    input  logic [BUF_ADDR_WIDTH-1:0] buf_read_addr,
    output logic [BUF_DATA_WIDTH-1:0] buf_read_data,
    input  logic                      drain_start,
    input  logic [MEM_ADDR_WIDTH-1:0] drain_base,
    input  logic [MEM_ADDR_WIDTH:0]   drain_count,
    output logic                      drain_busy,
    output logic                      drain_done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MEM_DATA_WIDTH-1:0] out_data,
    output logic                      out_last
);

    localparam int unsigned GSEL_W = (GRP_W > 0) ? GRP_W : 1;
    localparam int unsigned CNT_W  = MEM_ADDR_WIDTH + 1;
    localparam int unsigned PTR_W  = idx_width(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned OCC_W  = PTR_W + 2;

    state_e                      state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic                        issue;
    logic                        pop;
    logic [OCC_W-1:0]            occ;
    logic [BUF_ADDR_WIDTH-1:0]   drain_row;
    logic [GSEL_W-1:0]           drain_grp;
    logic [BUF_DATA_WIDTH-1:0]   drain_row_data;

    logic                        rd_vld_q;
    logic                        rd_last_q;
    logic [GSEL_W-1:0]           grp_q;
    logic [MEM_DATA_WIDTH-1:0]   sel_word;

    logic [MEM_DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]       fifo_last_q;
    logic [PTR_W-1:0]            wptr_q;
    logic [PTR_W-1:0]            rptr_q;
    logic [FCNT_W-1:0]           fcnt_q;
    logic                        head_last;

    // Split the drain word address into buffer row and lane group.
    assign drain_row = BUF_ADDR_WIDTH'(addr_q >> GRP_W);
    assign drain_grp = GSEL_W'(addr_q & MEM_ADDR_WIDTH'(NUM_GROUPS - 1));

    // Lane RAMs: port A serves the array side, port B the drain.
    for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
        obuf_lane_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (BUF_ADDR_WIDTH)
        ) u_ram (
            .clk       (clk),
            .reset     (reset),
            .we_i      (buf_write_req),
            .waddr_i   (buf_write_addr),
            .wdata_i   (buf_write_data[m*DATA_WIDTH +: DATA_WIDTH]),
            .re_a_i    (buf_read_req),
            .raddr_a_i (buf_read_addr),
            .rdata_a_o (buf_read_data[m*DATA_WIDTH +: DATA_WIDTH]),
            .re_b_i    (issue),
            .raddr_b_i (drain_row),
            .rdata_b_o (drain_row_data[m*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Issue a read only while the FIFO can absorb everything already in flight.
    assign pop   = out_valid && out_ready;
    assign occ   = OCC_W'(fcnt_q) + OCC_W'(rd_vld_q) - OCC_W'(pop);
    assign issue = (state_q == ST_RUN) && (occ < OCC_W'(FIFO_DEPTH));

    // Drain sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (drain_start) begin
                    if (drain_count != '0) begin
                        addr_d  = drain_base;
                        cnt_d   = drain_count;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + MEM_ADDR_WIDTH'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && head_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Drain sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Track the read in the RAM stage together with its group id and last flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            grp_q     <= '0;
        end else begin
            rd_vld_q <= issue;
            if (issue) begin
                rd_last_q <= (cnt_q == CNT_W'(1));
                grp_q     <= drain_grp;
            end
        end
    end

    // Pick the lane group out of the RAM row using the delayed group id.
    always_comb begin
        sel_word = drain_row_data[MEM_DATA_WIDTH-1:0];
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (grp_q == GSEL_W'(g)) begin
                sel_word = drain_row_data[g*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            end
        end
    end

    // The group select is registered straight into the FIFO slot.
    always_ff @(posedge clk) begin
        if (rd_vld_q) begin
            fifo_data_q[wptr_q] <= sel_word;
        end
    end

    // FIFO pointers, occupancy and per-entry last flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            fcnt_q      <= '0;
            fifo_last_q <= '0;
        end else begin
            if (rd_vld_q) begin
                fifo_last_q[wptr_q] <= rd_last_q;
                wptr_q              <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            fcnt_q <= fcnt_q + FCNT_W'(rd_vld_q) - FCNT_W'(pop);
        end
    end

    assign head_last  = fifo_last_q[rptr_q];
    assign out_valid  = (fcnt_q != '0);
    assign out_data   = out_valid ? fifo_data_q[rptr_q] : '0;
    assign out_last   = out_valid && head_last;
    assign drain_busy = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign drain_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_obuf_drain.sv
// Directed bench for obuf_drain with a scoreboard of expected drain words.
module tb_obuf_drain;

    localparam int unsigned AM  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned MDW = 64;
    localparam int unsigned BAW = 4;
    localparam int unsigned MAW = 5;
    localparam int unsigned BDW = AM * DW;

    typedef struct packed {
        logic           last;
        logic [MDW-1:0] data;
    } word_t;

    logic           clk;
    logic           reset;
    logic           buf_write_req;
    logic [BAW-1:0] buf_write_addr;
    logic [BDW-1:0] buf_write_data;
    logic           buf_read_req;
    logic [BAW-1:0] buf_read_addr;
    logic [BDW-1:0] buf_read_data;
    logic           drain_start;
    logic [MAW-1:0] drain_base;
    logic [MAW:0]   drain_count;
    logic           drain_busy;
    logic           drain_done;
    logic           out_valid;
    logic           out_ready;
    logic [MDW-1:0] out_data;
    logic           out_last;

    int    total;
    int    bad;
    int    nwords;
    word_t sb[$];
    logic [31:0] mdl [16][4];

    logic           hold_v;
    word_t          hold_w;

    obuf_drain #(
        .ARRAY_M        (AM),
        .DATA_WIDTH     (DW),
        .MEM_DATA_WIDTH (MDW),
        .BUF_ADDR_WIDTH (BAW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .buf_write_req  (buf_write_req),
        .buf_write_addr (buf_write_addr),
        .buf_write_data (buf_write_data),
        .buf_read_req   (buf_read_req),
        .buf_read_addr  (buf_read_addr),
        .buf_read_data  (buf_read_data),
        .drain_start    (drain_start),
        .drain_base     (drain_base),
        .drain_count    (drain_count),
        .drain_busy     (drain_busy),
        .drain_done     (drain_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] row_model(input int r);
        return {mdl[r][3], mdl[r][2], mdl[r][1], mdl[r][0]};
    endfunction

    function automatic word_t exp_word(input int a, input logic last);
        word_t w;
        int    row;
        int    g;
        row    = (a >> 1) & 15;
        g      = a & 1;
        w.data = {mdl[row][2*g+1], mdl[row][2*g]};
        w.last = last;
        return w;
    endfunction

    task automatic wr_row(input int row, input logic [127:0] d);
        buf_write_req  = 1'b1;
        buf_write_addr = BAW'(row);
        buf_write_data = d;
        for (int l = 0; l < 4; l++) mdl[row][l] = d[l*32 +: 32];
        cyc();
        buf_write_req = 1'b0;
    endtask

    // Drives drain_start for one cycle and queues the expected words.
    task automatic start_drain(input int base, input int count);
        drain_start = 1'b1;
        drain_base  = MAW'(base);
        drain_count = (MAW+1)'(count);
        for (int i = 0; i < count; i++) begin
            sb.push_back(exp_word((base + i) % 32, (i == count - 1)));
        end
        cyc();
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit toggle);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            if (drain_done) begin
                seen = 1'b1;
            end else begin
                if (toggle) out_ready = ~out_ready;
                cyc();
                n++;
            end
        end
        out_ready = 1'b1;
        total++;
        assert (seen) else begin
            bad++;
            $error("FAIL %s_done_timeout observed=0 expected=1", tag);
        end
        chk({tag, "_sb_left"}, 128'(sb.size()), 128'(0));
    endtask

    // Output monitor: scoreboard compare on accept, stability check on stall.
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("stall_hold", {63'd0, out_valid, out_last, out_data}, {63'd0, 1'b1, hold_w});
            hold_v = out_valid && !out_ready;
            hold_w = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    assert (sb.size() != 0) else begin
                        bad++;
                        $error("FAIL unexpected_word observed=%0h expected=none", out_data);
                    end
                end else begin
                    word_t e;
                    e = sb.pop_front();
                    chk("word_data", 128'(out_data), 128'(e.data));
                    chk("word_last", 128'(out_last), 128'(e.last));
                end
                nwords++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] old_row;
        logic [127:0] new_row;
        int           nw0;
        int           n;

        total = 0; bad = 0; nwords = 0; hold_v = 1'b0; hold_w = '0;
        reset = 1'b1;
        buf_write_req = 1'b0; buf_write_addr = '0; buf_write_data = '0;
        buf_read_req = 1'b0; buf_read_addr = '0;
        drain_start = 1'b0; drain_base = '0; drain_count = '0;
        out_ready = 1'b1;
        repeat (3) cyc();

        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_busy", 128'(drain_busy), 128'(0));
        chk("rst_done", 128'(drain_done), 128'(0));
        chk("rst_buf_rd", buf_read_data, 128'(0));
        reset = 1'b0;
        cyc();

        for (int r = 0; r < 16; r++) begin
            wr_row(r, {32'h1000_0003 + 32'(r << 8), 32'h1000_0002 + 32'(r << 8),
                       32'h1000_0001 + 32'(r << 8), 32'h1000_0000 + 32'(r << 8)});
        end

        // Basic drain of row 2 with exact latency checks.
        wr_row(2, {32'hD, 32'hC, 32'hB, 32'hA});
        buf_read_req  = 1'b1;
        buf_read_addr = 4'd2;
        cyc();
        buf_read_req  = 1'b0;
        buf_read_addr = 4'd3;
        chk("buf_rd_row2", buf_read_data, 128'h0000000D_0000000C_0000000B_0000000A);
        cyc();
        cyc();
        chk("buf_rd_hold", buf_read_data, 128'h0000000D_0000000C_0000000B_0000000A);

        start_drain(4, 2);
        chk("c1_busy", 128'(drain_busy), 128'(1));
        cyc();
        chk("c2_valid", 128'(out_valid), 128'(0));
        cyc();
        chk("c3_valid", 128'(out_valid), 128'(1));
        chk("c3_data", 128'(out_data), 128'h0000000B_0000000A);
        chk("c3_last", 128'(out_last), 128'(0));
        cyc();
        chk("c4_data", 128'(out_data), 128'h0000000D_0000000C);
        chk("c4_last", 128'(out_last), 128'(1));
        chk("c4_done", 128'(drain_done), 128'(0));
        cyc();
        chk("c5_done", 128'(drain_done), 128'(1));
        chk("c5_busy", 128'(drain_busy), 128'(0));
        chk("c5_sb_left", 128'(sb.size()), 128'(0));
        cyc();
        chk("c6_done", 128'(drain_done), 128'(0));

        // Backpressure: ready toggling every cycle.
        nw0 = nwords;
        start_drain(0, 8);
        wait_done("stall8", 60, 1'b1);
        chk("stall8_count", 128'(nwords - nw0), 128'(8));
        cyc();

        // Address wrap at the top of the word space.
        nw0 = nwords;
        start_drain(30, 4);
        wait_done("wrap", 40, 1'b0);
        chk("wrap_count", 128'(nwords - nw0), 128'(4));
        cyc();

        // Zero-length drain.
        start_drain(7, 0);
        chk("zero_done", 128'(drain_done), 128'(1));
        chk("zero_busy", 128'(drain_busy), 128'(0));
        chk("zero_valid", 128'(out_valid), 128'(0));
        cyc();
        chk("zero_done_off", 128'(drain_done), 128'(0));
        chk("zero_valid2", 128'(out_valid), 128'(0));
        cyc();

        // Reset in the middle of a drain.
        nw0 = nwords;
        start_drain(0, 8);
        n = 0;
        while (nwords < nw0 + 3 && n < 40) begin
            cyc();
            n++;
        end
        chk("mid_words_seen", 128'(nwords >= nw0 + 3), 128'(1));
        reset = 1'b1;
        cyc();
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_last", 128'(out_last), 128'(0));
        chk("mid_rst_data", 128'(out_data), 128'(0));
        chk("mid_rst_busy", 128'(drain_busy), 128'(0));
        chk("mid_rst_done", 128'(drain_done), 128'(0));
        chk("mid_rst_buf_rd", buf_read_data, 128'(0));
        sb.delete();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_no_done", 128'(drain_done), 128'(0));
            chk("post_rst_no_valid", 128'(out_valid), 128'(0));
        end
        nw0 = nwords;
        start_drain(0, 8);
        wait_done("after_rst", 40, 1'b0);
        chk("after_rst_count", 128'(nwords - nw0), 128'(8));
        cyc();

        // Same-cycle write and drain/buf read of row 5 return old data.
        old_row = row_model(5);
        new_row = 128'h5555_0003_5555_0002_5555_0001_5555_0000;
        start_drain(10, 1);
        buf_write_req  = 1'b1;
        buf_write_addr = 4'd5;
        buf_write_data = new_row;
        buf_read_req   = 1'b1;
        buf_read_addr  = 4'd5;
        for (int l = 0; l < 4; l++) mdl[5][l] = new_row[l*32 +: 32];
        cyc();
        buf_write_req = 1'b0;
        buf_read_req  = 1'b0;
        chk("coll_buf_old", buf_read_data, old_row);
        wait_done("coll_old", 40, 1'b0);
        cyc();
        start_drain(10, 1);
        wait_done("coll_new", 40, 1'b0);
        buf_read_req  = 1'b1;
        buf_read_addr = 4'd5;
        cyc();
        buf_read_req = 1'b0;
        chk("coll_buf_new", buf_read_data, new_row);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
